// File: rtl/boreal_norm_scheduler.sv
// Round-robin frame scheduler in front of a shared feature normalizer.
// Three requesters, one frame in flight, EMA lock gated by warm-up count.
module boreal_norm_scheduler #(
   parameter int WARMUP_FRAMES = 64,
   parameter int TIMEOUT_CYC   = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   req_valid,
   input  logic [383:0] req_data,
   output logic [2:0]   req_ready,
   input  logic         ctrl_active,
   output logic         norm_valid,
   output logic [127:0] norm_features,
   output logic         norm_lock,
   input  logic         norm_done,
   input  logic [127:0] norm_result,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [127:0] res_data,
   output logic [1:0]   res_tag,
   output logic         timeout_err,
   output logic         warm
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   localparam logic [7:0] TMAX = 8'(TIMEOUT_CYC - 1);
   localparam logic [7:0] WMAX = 8'(WARMUP_FRAMES);
   localparam logic [7:0] WPRE = 8'(WARMUP_FRAMES - 1);

   logic [1:0] state;
   logic [1:0] rr_ptr;
   logic [7:0] timer;
   logic [7:0] frames;
   logic [1:0] tag;

   logic [1:0]   cand0;
   logic [1:0]   cand1;
   logic [1:0]   cand2;
   logic [1:0]   gnt;
   logic         any_req;
   logic [127:0] gnt_data;

   function automatic logic [1:0] nxt(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   function automatic logic pick(
      input logic [2:0] v,
      input logic [1:0] i
   );
      logic r;
      r = 1'b0;
      unique case (i)
         2'd0:    r = v[0];
         2'd1:    r = v[1];
         default: r = v[2];
      endcase
      return r;
   endfunction

   // Search order starts at rr_ptr and wraps modulo 3.
   always_comb begin
      any_req = |req_valid;
      cand0   = rr_ptr;
      cand1   = nxt(rr_ptr);
      cand2   = nxt(cand1);
      if (pick(req_valid, cand0)) begin
         gnt = cand0;
      end else if (pick(req_valid, cand1)) begin
         gnt = cand1;
      end else begin
         gnt = cand2;
      end
   end

   always_comb begin
      gnt_data = req_data[127:0];
      unique case (gnt)
         2'd1:    gnt_data = req_data[255:128];
         2'd2:    gnt_data = req_data[383:256];
         default: gnt_data = req_data[127:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         rr_ptr        <= '0;
         timer         <= '0;
         frames        <= '0;
         tag           <= '0;
         req_ready     <= '0;
         norm_valid    <= 1'b0;
         norm_features <= '0;
         norm_lock     <= 1'b0;
         res_valid     <= 1'b0;
         res_data      <= '0;
         res_tag       <= '0;
         timeout_err   <= 1'b0;
         warm          <= 1'b0;
      end else begin
         req_ready   <= '0;
         norm_valid  <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  req_ready     <= 3'b001 << gnt;
                  norm_valid    <= 1'b1;
                  norm_features <= gnt_data;
                  norm_lock     <= ctrl_active & warm;
                  tag           <= gnt;
                  timer         <= '0;
                  rr_ptr        <= nxt(gnt);
                  state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A done that lands on the last timer cycle still wins.
               if (norm_done) begin
                  res_data  <= norm_result;
                  res_tag   <= tag;
                  res_valid <= 1'b1;
                  state     <= S_OUT;
                  if (frames != WMAX) begin
                     frames <= frames + 8'd1;
                  end
                  if (frames == WPRE) begin
                     warm <= 1'b1;
                  end
               end else if (timer == TMAX) begin
                  timeout_err <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            S_OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_boreal_norm_scheduler.sv
// Bench for boreal_norm_scheduler: directed frame table, reset
// corner, and randomized frames against a transaction-level model.
module tb_boreal_norm_scheduler;

   localparam int W_B = 2;
   localparam int T_B = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   req_valid;
   logic [383:0] req_data;
   logic         ctrl_active;
   logic         norm_done;
   logic [127:0] norm_result;
   logic         res_ready;

   logic [2:0]   a_req_ready, b_req_ready;
   logic         a_norm_valid, b_norm_valid;
   logic [127:0] a_norm_features, b_norm_features;
   logic         a_norm_lock, b_norm_lock;
   logic         a_res_valid, b_res_valid;
   logic [127:0] a_res_data, b_res_data;
   logic [1:0]   a_res_tag, b_res_tag;
   logic         a_timeout_err, b_timeout_err;
   logic         a_warm, b_warm;

   boreal_norm_scheduler dut_a (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data),
      .req_ready(a_req_ready), .ctrl_active(ctrl_active),
      .norm_valid(a_norm_valid), .norm_features(a_norm_features),
      .norm_lock(a_norm_lock), .norm_done(norm_done),
      .norm_result(norm_result), .res_valid(a_res_valid),
      .res_ready(res_ready), .res_data(a_res_data),
      .res_tag(a_res_tag), .timeout_err(a_timeout_err),
      .warm(a_warm)
   );

   boreal_norm_scheduler #(
      .WARMUP_FRAMES(W_B), .TIMEOUT_CYC(T_B)
   ) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data),
      .req_ready(b_req_ready), .ctrl_active(ctrl_active),
      .norm_valid(b_norm_valid), .norm_features(b_norm_features),
      .norm_lock(b_norm_lock), .norm_done(norm_done),
      .norm_result(norm_result), .res_valid(b_res_valid),
      .res_ready(res_ready), .res_data(b_res_data),
      .res_tag(b_res_tag), .timeout_err(b_timeout_err),
      .warm(b_warm)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   int           m_ptr;
   int           m_cnt;
   logic [2:0]   pend;
   logic [127:0] pdat[3];

   typedef struct {
      logic ctrl;
      logic mid;
      int   lat;
      int   hold;
      int   eg;
      logic elock;
      logic ewarm;
   } vec_t;

   vec_t tv[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic apply_req();
      for (int r = 0; r < 3; r++) req_data[r*128 +: 128] = pdat[r];
      req_valid = pend;
   endtask

   task automatic refill(input logic [2:0] m);
      for (int r = 0; r < 3; r++) begin
         if (m[r] && !pend[r]) begin
            pdat[r] = rnd128();
            pend[r] = 1'b1;
         end
      end
   endtask

   function automatic int pick(input int ptr, input logic [2:0] p);
      for (int j = 0; j < 3; j++) begin
         if (p[(ptr + j) % 3]) return (ptr + j) % 3;
      end
      return -1;
   endfunction

   // One frame on dut_b; lat > T_B means the normalizer never answers.
   task automatic do_frame(input int eg, input logic elock, input int lat,
                           input int hold, input logic mid,
                           input logic ewarm);
      int n;
      logic [127:0] res;
      logic [2:0] onehot;
      apply_req();
      n = 0;
      do begin
         step();
         n++;
      end while (!b_norm_valid && n < 4);
      chk("grant_latency", n, 1);
      if (!b_norm_valid) return;
      onehot = 3'b001 << eg;
      chk("req_ready", b_req_ready, onehot);
      chk("norm_features", b_norm_features, pdat[eg]);
      chk("norm_lock", b_norm_lock, elock);
      chk("grant_timeout_err", b_timeout_err, 0);
      pend[eg] = 1'b0;
      apply_req();
      if (mid) ctrl_active = ~ctrl_active;
      if (lat > T_B) begin
         for (int i = 1; i < T_B; i++) step();
         chk("early_timeout", b_timeout_err, 0);
         step();
         chk("timeout_err", b_timeout_err, 1);
         chk("timeout_res_valid", b_res_valid, 0);
         chk("timeout_warm", b_warm, ewarm);
         chk("lock_hold", b_norm_lock, elock);
      end else begin
         for (int i = 1; i < lat; i++) step();
         res = rnd128();
         norm_result = res;
         norm_done = 1'b1;
         step();
         norm_done = 1'b0;
         chk("res_valid", b_res_valid, 1);
         chk("res_data", b_res_data, res);
         chk("res_tag", b_res_tag, eg);
         chk("done_timeout_err", b_timeout_err, 0);
         chk("warm", b_warm, ewarm);
         chk("lock_hold", b_norm_lock, elock);
         for (int i = 0; i < hold; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               norm_done = 1'b1;
               norm_result = ~res;
            end
            step();
            norm_done = 1'b0;
            chk("bp_res_valid", b_res_valid, 1);
            chk("bp_res_data", b_res_data, res);
            chk("bp_res_tag", b_res_tag, eg);
            chk("bp_req_ready", b_req_ready, 0);
         end
         res_ready = 1'b1;
         step();
         res_ready = 1'b0;
         chk("release_res_valid", b_res_valid, 0);
         chk("release_req_ready", b_req_ready, 0);
      end
   endtask

   task automatic chk_zero_b(input string nm);
      chk({nm, "_req_ready"}, b_req_ready, 0);
      chk({nm, "_norm_valid"}, b_norm_valid, 0);
      chk({nm, "_norm_features"}, b_norm_features, 0);
      chk({nm, "_norm_lock"}, b_norm_lock, 0);
      chk({nm, "_res_valid"}, b_res_valid, 0);
      chk({nm, "_res_data"}, b_res_data, 0);
      chk({nm, "_res_tag"}, b_res_tag, 0);
      chk({nm, "_timeout_err"}, b_timeout_err, 0);
      chk({nm, "_warm"}, b_warm, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] a_dat;
      logic [127:0] a_res;
      int eg;
      int lat;
      logic elock;
      logic ewarm;
      logic [2:0] m;

      tv[0] = '{1'b1, 1'b0, 3, 2, 0, 1'b0, 1'b0};
      tv[1] = '{1'b1, 1'b0, 8, 0, 1, 1'b0, 1'b1};
      tv[2] = '{1'b1, 1'b1, 5, 10, 2, 1'b1, 1'b1};
      tv[3] = '{1'b0, 1'b0, 2, 0, 0, 1'b0, 1'b1};
      tv[4] = '{1'b1, 1'b0, 1, 1, 1, 1'b1, 1'b1};
      tv[5] = '{1'b1, 1'b0, 4, 0, 2, 1'b1, 1'b1};
      tv[6] = '{1'b1, 1'b0, 9, 0, 0, 1'b1, 1'b1};

      rst = 1'b1;
      req_valid = '0;
      req_data = '0;
      ctrl_active = 1'b0;
      norm_done = 1'b0;
      norm_result = '0;
      res_ready = 1'b0;
      pend = '0;
      for (int r = 0; r < 3; r++) pdat[r] = '0;
      step();
      step();
      chk_zero_b("reset");
      chk("reset_a_res_valid", a_res_valid, 0);
      rst = 1'b0;

      // Long-latency single request on the default-parameter instance.
      a_dat = rnd128();
      a_res = rnd128();
      pdat[0] = a_dat;
      pend = 3'b001;
      res_ready = 1'b1;
      apply_req();
      step();
      chk("a_req_ready", a_req_ready, 3'b001);
      chk("a_norm_valid", a_norm_valid, 1);
      chk("a_norm_features", a_norm_features, a_dat);
      pend = '0;
      apply_req();
      for (int i = 1; i < 26; i++) step();
      chk("a_no_early_res", a_res_valid, 0);
      norm_result = a_res;
      norm_done = 1'b1;
      step();
      norm_done = 1'b0;
      chk("a_res_valid", a_res_valid, 1);
      chk("a_res_tag", a_res_tag, 0);
      chk("a_res_data", a_res_data, a_res);
      step();
      res_ready = 1'b0;
      chk("a_res_release", a_res_valid, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_zero_b("reset2");

      // Directed frames: fairness, lock gating, boundary done, timeout.
      for (int k = 0; k < 7; k++) begin
         refill(3'b111);
         ctrl_active = tv[k].ctrl;
         do_frame(tv[k].eg, tv[k].elock, tv[k].lat, tv[k].hold,
                  tv[k].mid, tv[k].ewarm);
      end

      // Reset in the middle of WAIT, then a stray done.
      refill(3'b111);
      ctrl_active = 1'b1;
      apply_req();
      step();
      chk("rst_pre_grant", b_req_ready, 3'b010);
      pend = '0;
      apply_req();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_zero_b("midwait_reset");
      norm_result = rnd128();
      norm_done = 1'b1;
      step();
      norm_done = 1'b0;
      chk("stray_res_valid", b_res_valid, 0);
      chk("stray_norm_valid", b_norm_valid, 0);
      step();
      chk("stray_res_valid2", b_res_valid, 0);
      refill(3'b111);
      do_frame(0, 1'b0, 4, 1, 1'b0, 1'b0);
      m_ptr = 1;
      m_cnt = 1;

      // Randomized frames against the transaction model.
      for (int f = 0; f < 150; f++) begin
         if (pend == 0 && $urandom_range(0, 1) == 1) begin
            for (int c = 0; c < $urandom_range(1, 3); c++) begin
               req_valid = '0;
               norm_done = 1'($urandom_range(0, 1));
               norm_result = rnd128();
               step();
               norm_done = 1'b0;
               chk("gap_norm_valid", b_norm_valid, 0);
               chk("gap_req_ready", b_req_ready, 0);
               chk("gap_res_valid", b_res_valid, 0);
            end
         end
         m = 3'($urandom_range(0, 7));
         if ((pend | m) == 0) m = 3'b001 << $urandom_range(0, 2);
         refill(m);
         ctrl_active = 1'($urandom_range(0, 1));
         eg = pick(m_ptr, pend);
         elock = ctrl_active && (m_cnt == W_B);
         lat = $urandom_range(1, T_B + 1);
         if (lat <= T_B) m_cnt = (m_cnt + 1 > W_B) ? W_B : m_cnt + 1;
         ewarm = (m_cnt == W_B);
         m_ptr = (eg + 1) % 3;
         do_frame(eg, elock, lat, $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), ewarm);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/boreal_norm_scheduler.md
BOREAL_NORM_SCHEDULER -- requirements
Module: boreal_norm_scheduler

Interface
REQ-001 SHALL have parameter WARMUP_FRAMES, default 64: completed frames before the EMA lock may engage (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64: WAIT cycles before a missing normalizer done is declared (range 1..255).
REQ-003 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  3  per-requester frame request; held high until the matching req_ready.
REQ-006 SHALL have port req_data  in  384  three 128-bit frames; requester i occupies bits [i*128 +: 128].
REQ-007 SHALL have port req_ready  out  3  one-cycle grant/accept pulse, one-hot.
REQ-008 SHALL have port ctrl_active  in  1  closed-loop control active; requests EMA freeze.
REQ-009 SHALL have port norm_valid  out  1  one-cycle start pulse to the normalizer.
REQ-010 SHALL have port norm_features  out  128  frame presented to the normalizer.
REQ-011 SHALL have port norm_lock  out  1  EMA freeze to the normalizer.
REQ-012 SHALL have port norm_done  in  1  normalizer completion pulse.
REQ-013 SHALL have port norm_result  in  128  normalized frame, valid with norm_done.
REQ-014 SHALL have port res_valid  out  1  result available; held until res_ready.
REQ-015 SHALL have port res_ready  in  1  downstream accepts the result.
REQ-016 SHALL have port res_data  out  128  normalized frame.
REQ-017 SHALL have port res_tag  out  2  index of the requester that owns res_data.
REQ-018 SHALL have port timeout_err  out  1  one-cycle pulse on a normalizer timeout.
REQ-019 SHALL have port warm  out  1  high once WARMUP_FRAMES frames have completed.

Function
REQ-020 SHALL implement a three-state FSM: IDLE, WAIT, and OUT; all outputs are registered.
REQ-021 In IDLE with any req_valid high, SHALL grant round-robin.
  - Search starts at rr_ptr, then rr_ptr+1, wrapping modulo 3.
  - On the grant edge: req_ready[g]=1 for one cycle, norm_valid=1 for one cycle, norm_features=req_data[g], tag=g, timer=0, rr_ptr=(g+1) mod 3, state moves to WAIT.
REQ-022 In IDLE with no req_valid, SHALL hold all state; req_ready and norm_valid stay 0.
REQ-023 SHALL update norm_lock only on the grant edge, to ctrl_active AND warm.
  - norm_lock stays constant for the whole frame.
  - A ctrl_active change mid-frame takes effect at the next grant.
REQ-024 In WAIT, SHALL increment the timer by 1 each cycle while norm_done is low.
REQ-025 In WAIT with norm_done high, SHALL register the result and move to OUT.
  - Registers res_data=norm_result, res_tag=tag, res_valid=1.
  - Increments the frame counter, saturating at WARMUP_FRAMES.
REQ-026 In WAIT with timer equal to TIMEOUT_CYC-1 and norm_done low, SHALL pulse timeout_err for one cycle and return to IDLE.
  - No res_valid is produced; the frame counter is unchanged.
REQ-027 If norm_done and the timeout condition occur in the same cycle, SHALL treat the frame as completed (REQ-025); no timeout_err.
REQ-028 In OUT, SHALL hold res_valid, res_data and res_tag stable until res_ready is high.
  - On that edge: res_valid=0, state moves to IDLE.
  - A grant is possible no earlier than the following edge.
REQ-029 SHALL ignore norm_done in IDLE and OUT: no state change, no counter change.
REQ-030 SHALL drive warm=1 exactly when the frame counter equals WARMUP_FRAMES; once high, it stays high until reset.
REQ-031 SHALL ignore req_valid outside IDLE; req_ready is never asserted outside the grant edge.
REQ-032 SHALL give a minimum frame turnaround of grant edge + normalizer latency + 1 (OUT) + 1 (IDLE) cycles.

Reset
REQ-033 On rst, at any state including mid-WAIT or OUT, SHALL clear the following to 0: state=IDLE, rr_ptr, timer, frame counter, tag, req_ready, norm_valid, norm_features, norm_lock, res_valid, res_data, res_tag, timeout_err and warm.
REQ-034 SHALL discard any in-flight frame on reset; a norm_done arriving after reset is ignored per REQ-029.

Verification
REQ-035 Single request: req_valid=3'b001, data A, normalizer returns done after 26 cycles, res_ready=1 -> req_ready=001 and norm_valid on the same edge; res_valid=1 with res_tag=0 and res_data=result; counter=1.
REQ-036 Fairness: all three requesters held high for 6 frames -> grant order 0,1,2,0,1,2; each tag appears exactly twice.
REQ-037 Lock gating: WARMUP_FRAMES=2, ctrl_active=1 throughout -> norm_lock=0 for frames 1-2, warm rises after frame 2 completes, norm_lock=1 from the frame-3 grant; ctrl_active dropped mid-frame 3 -> lock still 1 until the frame-4 grant.
REQ-038 Timeout: TIMEOUT_CYC=8, no norm_done -> timeout_err pulses 8 cycles after the grant, no res_valid, state IDLE; norm_done on exactly the 8th cycle instead -> res_valid, no timeout_err.
REQ-039 Backpressure: res_ready=0 for 10 cycles with requester 1 pending -> res_valid, res_data and res_tag stable; no req_ready until 2 edges after res_ready rises.
REQ-040 Reset mid-WAIT, followed by a stray norm_done -> all outputs 0, no res_valid, counter 0, next grant goes to requester 0.
